// File: rtl/rs_seg_pipe_alu.sv
// Pipelined wide adder/subtractor: one SEG_WIDTH-bit segment resolved per stage, carries registered between stages.
// Optional overflow output V is built when RS_ALU_OVERFLOW_EN is defined.
module rs_seg_pipe_alu #(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16   // keep <= `MAX_CARRY_CHAIN of the target
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] X,
  output logic             CO
`ifdef RS_ALU_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // A result held with out_ready=0 freezes every stage (global stall), so in_ready drops too.
  logic             stall;
  logic [WIDTH-1:0] bb;

  assign bb = BI ? ~B : B;

  for (genvar g = 0; g < NSEG; g++) begin : stg
    localparam int LO = g * SEG_WIDTH;
    localparam int HI = ((g + 1) * SEG_WIDTH < WIDTH) ? (g + 1) * SEG_WIDTH - 1 : WIDTH - 1;
    localparam int SW = HI - LO + 1;

    logic [SW-1:0]    a_seg;
    logic [SW-1:0]    b_seg;
    logic             cin;
    logic             vld_in;
    logic [WIDTH-1:0] x_in;
    logic [SW:0]      sum;
    logic [HI:0]      y_nxt;

    logic             vld;
    logic             c_r;
    logic [HI:0]      y_r;
    logic [WIDTH-1:0] x_r;

    assign sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, cin};

    if (g == 0) begin : g_src
      assign a_seg  = A[HI:0];
      assign b_seg  = bb[HI:0];
      assign cin    = CI;
      assign vld_in = in_valid;
      assign x_in   = A ^ bb;
      assign y_nxt  = sum[SW-1:0];
    end else begin : g_src
      assign a_seg  = stg[g-1].g_fwd.a_r[SW-1:0];
      assign b_seg  = stg[g-1].g_fwd.b_r[SW-1:0];
      assign cin    = stg[g-1].c_r;
      assign vld_in = stg[g-1].vld;
      assign x_in   = stg[g-1].x_r;
      assign y_nxt  = {sum[SW-1:0], stg[g-1].y_r};
    end

    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        vld <= 1'b0;
        c_r <= 1'b0;
        y_r <= '0;
        x_r <= '0;
      end else if (!stall) begin
        vld <= vld_in;
        c_r <= sum[SW];
        y_r <= y_nxt;
        x_r <= x_in;
      end
    end

    // Operand bits above this segment ride along until their own stage.
    if (g < NSEG - 1) begin : g_fwd
      localparam int REM = WIDTH - HI - 1;
      logic [REM-1:0] a_in;
      logic [REM-1:0] b_in;
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;

      if (g == 0) begin : g_sel
        assign a_in = A[WIDTH-1:HI+1];
        assign b_in = bb[WIDTH-1:HI+1];
      end else begin : g_sel
        assign a_in = stg[g-1].g_fwd.a_r[WIDTH-LO-1:SW];
        assign b_in = stg[g-1].g_fwd.b_r[WIDTH-LO-1:SW];
      end

      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          a_r <= '0;
          b_r <= '0;
        end else if (!stall) begin
          a_r <= a_in;
          b_r <= b_in;
        end
      end
    end

`ifdef RS_ALU_OVERFLOW_EN
    // Carry into the MSB equals sum_msb ^ propagate_msb.
    if (g == NSEG - 1) begin : g_ovf
      logic v_r;
      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          v_r <= 1'b0;
        end else if (!stall) begin
          v_r <= x_in[WIDTH-1] ^ sum[SW-1] ^ sum[SW];
        end
      end
    end
`endif
  end

  assign out_valid = stg[NSEG-1].vld;
  assign Y         = stg[NSEG-1].y_r;
  assign X         = stg[NSEG-1].x_r;
  assign CO        = stg[NSEG-1].c_r;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
`ifdef RS_ALU_OVERFLOW_EN
  assign V         = stg[NSEG-1].g_ovf.v_r;
`endif

endmodule

// File: tb/tb_rs_seg_pipe_alu.sv
// Directed bench for rs_seg_pipe_alu: a 64/16 instance and a 40/16 instance (narrow last segment).
// V is checked when RS_ALU_OVERFLOW_EN is defined.
module tb_rs_seg_pipe_alu;

  // ---------------- clock / reset ----------------
  logic C;
  logic R;
  initial C = 1'b0;
  always #5 C = ~C;

  // 64-bit instance signals
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] A, B, Y, X;
  logic        CI, BI, CO;
  // 40-bit instance signals
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [39:0] w_A, w_B, w_Y, w_X;
  logic        w_CI, w_BI, w_CO;
`ifdef RS_ALU_OVERFLOW_EN
  logic        V, w_V;
`endif

  rs_seg_pipe_alu #(.WIDTH(64), .SEG_WIDTH(16)) dut (
    .C(C), .R(R),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CI(CI), .BI(BI),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .X(X), .CO(CO)
`ifdef RS_ALU_OVERFLOW_EN
    , .V(V)
`endif
  );

  rs_seg_pipe_alu #(.WIDTH(40), .SEG_WIDTH(16)) dut40 (
    .C(C), .R(R),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_A), .B(w_B), .CI(w_CI), .BI(w_BI),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .Y(w_Y), .X(w_X), .CO(w_CO)
`ifdef RS_ALU_OVERFLOW_EN
    , .V(w_V)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int total;
  int bad;
  int sent;
  int got;
  int lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic bi, input logic [63:0] ey,
                       input logic [63:0] ex, input logic eco, input logic ev);
    @(negedge C);
    out_ready = 1'b1;
    in_valid = 1'b1; A = a; B = b; CI = ci; BI = bi;
    @(negedge C);
    in_valid = 1'b0; A = {$urandom, $urandom}; B = {$urandom, $urandom};
    CI = 1'($urandom_range(0, 1)); BI = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge C);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_x"}, X, ex);
    chk({tag, "_co"}, {63'd0, CO}, {63'd0, eco});
`ifdef RS_ALU_OVERFLOW_EN
    chk({tag, "_v"}, {63'd0, V}, {63'd0, ev});
`endif
  endtask

  task automatic run40(input string tag, input logic [39:0] a, input logic [39:0] b,
                       input logic [39:0] ey, input logic [39:0] ex, input logic eco);
    @(negedge C);
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_A = a; w_B = b; w_CI = 1'b0; w_BI = 1'b0;
    @(negedge C);
    w_in_valid = 1'b0; w_A = 40'($urandom); w_B = 40'($urandom);
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(negedge C);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_y"}, {24'd0, w_Y}, {24'd0, ey});
    chk({tag, "_x"}, {24'd0, w_X}, {24'd0, ex});
    chk({tag, "_co"}, {63'd0, w_CO}, {63'd0, eco});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0; bad = 0;
    R = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; CI = 1'b0; BI = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_A = '0; w_B = '0; w_CI = 1'b0; w_BI = 1'b0; w_out_ready = 1'b1;
    repeat (2) @(negedge C);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", Y, 64'd0);
    chk("rst_x", X, 64'd0);
    chk("rst_co", {63'd0, CO}, 64'd0);
`ifdef RS_ALU_OVERFLOW_EN
    chk("rst_v", {63'd0, V}, 64'd0);
`endif
    R = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // single transactions, 64-bit
    run64("inc_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run64("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run64("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1,
          64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
    run64("seg_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0);
    run64("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    run64("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
    run64("small", 64'd3, 64'd4, 1'b0, 1'b0,
          64'd7, 64'd7, 1'b0, 1'b0);

    // back-to-back with a 3-cycle stall after the second result
    sent = 0; got = 0;
    for (int step = 0; step < 40 && got < 6; step++) begin
      @(negedge C);
      out_ready = !(step >= 6 && step <= 8);
      #1;
      if (step >= 6 && step <= 8) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_hold_y", Y, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("b2b_extra", {63'd0, out_valid}, 64'd0);
        end else begin
          chk("b2b_y", Y, exp_q.pop_front());
          got++;
        end
      end
      if (sent < 6) begin
        in_valid = 1'b1; A = 64'(sent); B = 64'h1_0000_0000; CI = 1'b0; BI = 1'b0;
        if (in_ready) begin
          exp_q.push_back(A + B);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_count", 64'(got), 64'd6);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge C);
      chk("b2b_no_dup", {63'd0, out_valid}, 64'd0);
    end

    // reset one cycle before the first of three results would emerge
    @(negedge C);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 64'(i); B = 64'd1;
      @(negedge C);
    end
    in_valid = 1'b0;
    R = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge C);
    R = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge C);
      if (out_valid) got++;
    end
    chk("midrst_no_result", 64'(got), 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    // out_valid must drop with R, without a clock edge
    @(negedge C);
    out_ready = 1'b0;
    in_valid = 1'b1; A = 64'd9; B = 64'd1; CI = 1'b0; BI = 1'b0;
    @(negedge C);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge C);
      lat++;
    end
    chk("async_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("async_pre_y", Y, 64'd10);
    #2;
    R = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_y", Y, 64'd0);
    @(negedge C);
    R = 1'b1;
    out_ready = 1'b1;

    // 40-bit instance: three stages, 8-bit last segment
    run40("w40_wrap", 40'hFF_FFFF_FFFF, 40'd1, 40'd0, 40'hFF_FFFF_FFFE, 1'b1);
    run40("w40_carry", 40'h00_0000_FFFF, 40'd1, 40'h00_0001_0000, 40'h00_0000_FFFE, 1'b0);
    run40("w40_last", 40'hFF_0000_0000, 40'h01_0000_0000, 40'd0, 40'hFE_0000_0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_seg_pipe_alu.md
Name: rs_seg_pipe_alu

Overview:
Parametrised, pipelined wide adder/subtractor for Genesis3. It is the successor to the single-chain $alu mapping, used when an operand is wider than one carry chain can carry in one cycle. Operands are split into SEG_WIDTH-bit segments, and one segment is resolved per pipeline stage on a dedicated carry chain. The carry between segments is registered. A valid/ready handshake wraps the pipeline, so the block sits between datapath FIFOs and the wide-counter and accumulator logic.

Parameters:
WIDTH, 64, operand/result width in bits (>=1)
SEG_WIDTH, 16, bits resolved per stage; must be <= `MAX_CARRY_CHAIN
NSEG, derived = ceil(WIDTH/SEG_WIDTH), pipeline depth; local, not overridable

Ports:
C  input  1  clock, rising edge
R  input  1  reset, asynchronous, active-low
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept a transaction this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
CI  input  1  carry-in of bit 0
BI  input  1  1 = invert B (subtract when CI=1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
Y  output  WIDTH  sum A + (BI ? ~B : B) + CI, modulo 2^WIDTH
X  output  WIDTH  propagate vector A ^ (BI ? ~B : B)
CO  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock C. R is an asynchronous, active-low reset.
- Reset state: R low clears every stage valid bit, all data/carry registers, out_valid, Y, X, CO and V to 0. in_ready is 1 once R is high.
- Stall control: stall = out_valid & ~out_ready. in_ready = ~stall.
  - When stall=0 the whole pipeline advances one stage per cycle. When stall=1 every register holds.
  - Bubbles are not collapsed. Stall is global.
- Accept: a transaction is accepted on a rising edge of C with in_valid & in_ready. On the same edge, stage 0 registers segment 0 of Y and X, the carry out of segment 0, and delayed copies of segments 1..NSEG-1 of A, BB and X.
- Stage k (1..NSEG-1): adds segment k of A and BB plus the registered carry from stage k-1 on its own carry chain. It forwards the completed lower result bits plus the new carry.
- Last segment: may be narrower (WIDTH mod SEG_WIDTH bits). Its carry out is CO.
- Latency: exactly NSEG cycles from the accept edge to out_valid=1, absent stalls. Throughput is one transaction per cycle.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Output hold: Y/X/CO/V hold stable while out_valid=1 and out_ready=0.
- NSEG=1: single registered stage, latency 1.
- Input changes: in_valid=1 while in_ready=0 is held off. Operands may change freely while not accepted.
- Reset mid-operation: in-flight transactions are discarded. out_valid drops asynchronously with R.
- Carry chain mapping: each segment adder maps to adder_carry primitives. Segment carries never cross a register boundary combinationally.

Optional Feature:
RS_ALU_OVERFLOW_EN:
- Defined: adds output V (1 bit), the two's-complement overflow of the full-width result. V = carry into bit WIDTH-1 XOR CO.
  - V is registered and aligned with Y.
  - V resets to 0 and holds under stall like Y.
- Undefined: port V does not exist and no extra logic is generated.

Test Plan:
- WIDTH=64, SEG=16: A=0xFFFF_FFFF_FFFF_FFFF, B=1, CI=0, BI=0 -> after 4 cycles out_valid=1, Y=0, CO=1, X=0xFFFF_FFFF_FFFF_FFFE.
- Subtract: A=5, B=7, CI=1, BI=1 -> Y=0xFFFF_FFFF_FFFF_FFFE, CO=0. Then A=7, B=5 -> Y=2, CO=1.
- Back-to-back and stall: 6 transactions (A=i, B=0x1_0000_0000, i=0..5) on consecutive cycles, with out_ready=0 for 3 cycles after the 2nd result:
  - in_ready is 0 throughout the stall.
  - Y sequence is 0x1_0000_0000+i, in order, with no loss or duplication.
  - The held output stays stable during the stall.
- Reset mid-flight: 3 transactions accepted, R pulsed low 1 cycle before the first would emerge -> out_valid=0 immediately. No result appears for 10 cycles after release. in_ready=1.
- WIDTH=40, SEG=16 (NSEG=3, last segment 8 bits): A=0xFF_FFFF_FFFF, B=1 -> latency 3, Y=0, CO=1. Also A=0x00_0000_FFFF, B=1 -> Y=0x00_0001_0000 (inter-segment carry).
- RS_ALU_OVERFLOW_EN defined, WIDTH=64:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> V=1, CO=0.
  - A=0x8000_0000_0000_0000, B=1, BI=1, CI=1 -> V=1.
  - A=3, B=4 -> V=0.
